// File: rtl/data_memory_param_if.sv
// Request/response bus between the load/store unit and data_memory_param.
// Parity signals exist only when DMEM_PARITY_EN is defined.
interface data_memory_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
);
    localparam int unsigned NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [NB-1:0]     req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
`ifdef DMEM_PARITY_EN
    logic              par_inject;
    logic              rsp_perr;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
`ifdef DMEM_PARITY_EN
        , output par_inject
        , input  rsp_perr
`endif
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
`ifdef DMEM_PARITY_EN
        , input  par_inject
        , output rsp_perr
`endif
    );
endinterface

// File: rtl/data_memory_param.sv
// Parametrised word-addressed data memory with byte enables, 1-cycle reads, zero-fill sweep
// after reset and out-of-range errors. Define DMEM_PARITY_EN for per-byte even parity.
module data_memory_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 41,
    parameter int unsigned ADDR_W = 6
) (
    input logic                 clk,
    input logic                 reset,
    data_memory_param_if.slave  bus
);
    localparam int unsigned NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_we;
    logic              accept;
    logic              in_range;
    logic              do_write;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef DMEM_PARITY_EN
    logic [NB-1:0]     par_mem [DEPTH];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        p = '0;
        for (int unsigned b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction
`endif

    assign accept   = bus.req_valid && bus.req_ready;
    assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
    assign do_write = accept && bus.req_write && in_range;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_CLEAR;
        else       state_q <= state_d;
    end

    // Next state: sweep ends after the last word is cleared; RUN is terminal
    always_comb begin
        state_d = state_q;
        if (state_q == S_CLEAR && clr_ptr == LAST_L) state_d = S_RUN;
    end

    // State outputs; req_ready stays combinational for back-to-back issue
    always_comb begin
        clr_we        = 1'b0;
        bus.req_ready = 1'b0;
        case (state_q)
            S_CLEAR: clr_we = 1'b1;
            S_RUN:   bus.req_ready = !bus.rsp_valid || bus.rsp_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       clr_ptr <= '0;
        else if (clr_we) clr_ptr <= clr_ptr + ADDR_W'(1);
    end

    // Storage has no reset; the sweep is the only initialisation
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
`ifdef DMEM_PARITY_EN
            par_mem[clr_ptr] <= '0;
`endif
        end else if (do_write) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (bus.req_be[b]) begin
                    mem[bus.req_addr][8*b +: 8] <= bus.req_wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
                    par_mem[bus.req_addr][b] <= (^bus.req_wdata[8*b +: 8]) ^ bus.par_inject;
`endif
                end
            end
        end
    end

    // Response register: payload changes only on acceptance, valid drops on consume
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
`ifdef DMEM_PARITY_EN
            bus.rsp_perr  <= 1'b0;
`endif
        end else if (accept) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= !in_range;
            bus.rsp_rdata <= (in_range && !bus.req_write) ? mem[bus.req_addr] : '0;
`ifdef DMEM_PARITY_EN
            bus.rsp_perr  <= in_range && !bus.req_write &&
                             (|(byte_par(mem[bus.req_addr]) ^ par_mem[bus.req_addr]));
`endif
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule
